mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and sequencer that shares one 4x4 shift-add multiplier between two requesters. Each requester posts operands with a level request. The block latches the winner's operands, pulses the multiplier's start, waits for its done flag, and returns the 8-bit product with a one-cycle ack. It sits between the two client FSMs and the multiplier top (start / done / product interface).

## Interface
- `DRAIN_CYC`, 15: cycles after reset release during which no grant is issued, letting an un-reset multiplier finish any in-flight operation.
- `TIMEOUT`, 31: WAIT-state cycle limit. Used only with `MULT_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0`, `req1` in 1 each: request level from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1` in 4 each: operands; held stable while the matching `req` is high.
- `ack0`, `ack1` out 1 each: one-cycle pulse; the matching product is valid.
- `p0`, `p1` out 8 each: product registers; hold their value until the next ack to that requester.
- `mult_start` out 1: one-cycle start pulse to the multiplier.
- `mult_a`, `mult_b` out 4 each: latched operands, stable from LAUNCH through WAIT.
- `mult_done` in 1: multiplier done level (cleared by start, set at completion).
- `mult_p` in 8: multiplier product.
- `busy` out 1: high in every state other than IDLE, and during drain.
- `owner` out 1: index of the current or most recent grantee.
- `err` out 1: timeout flag, qualified by ack. Exists only with the macro.

## Operation
- FSM states (2-bit): IDLE, LAUNCH, WAIT, DELIVER.
- **IDLE**
  - If the drain counter is nonzero, decrement it and grant nothing.
  - Otherwise, if any `req` is high: pick a winner, latch its operands into `mult_a`/`mult_b`, set `owner`, and go to LAUNCH.
- **Arbitration**
  - A single request wins outright.
  - If both requests are high, the requester that is not `last_gnt` wins.
  - `last_gnt` updates on each grant.
- **LAUNCH**
  - `mult_start`=1 for exactly this cycle.
  - Go to WAIT unconditionally.
- **WAIT**
  - Sample `mult_done`. When it is high, capture `mult_p` into `p[owner]` and go to DELIVER.
  - `mult_done` is not sampled in LAUNCH, because stale done is cleared at the LAUNCH edge.
- **DELIVER**
  - `ack[owner]`=1 for this cycle.
  - Go to IDLE.
- Requester rule: deassert `req` on the edge where `ack` is sampled high. A `req` still high in the following IDLE cycle is treated as a new request.
- Request changes during LAUNCH, WAIT or DELIVER are ignored. Operands are not re-sampled.
- Product width: `mult_p` is stored unmodified, 8 bits, with no truncation.

## Timing
- Reset values:
  - state IDLE
  - `mult_start`, `ack0`, `ack1`, `err` = 0
  - `mult_a`, `mult_b`, `p0`, `p1` = 0
  - `owner`=0, `last_gnt`=1, so requester 0 wins the first tie
  - drain counter = `DRAIN_CYC`, `busy`=1 until it reaches 0
- Reset asserted mid-operation: the FSM returns to IDLE the next edge, no ack is issued, the in-flight result is discarded, and the drain period restarts.
- Latency:
  - request seen in IDLE at cycle t → `mult_start` at t+1
  - `mult_done` first high at cycle d → `ack` and `p` valid at d+1
  - Minimum overhead is 3 cycles plus multiplier time.
- Back-to-back: the minimum gap between grants is one IDLE cycle after DELIVER.
- All outputs are registered except `busy`, which is decoded from state and drain count.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A 5-bit WAIT counter clears at LAUNCH.
  - If it reaches `TIMEOUT` without `mult_done`, go to DELIVER with `ack[owner]`=1, `err`=1 and `p[owner]`=0.
  - `err` is 0 on all normal acks.
- `MULT_ARB_TIMEOUT_EN` undefined: WAIT is unbounded, and the `err` port and counter are absent.

## Structure
- Package `mult_arb_pkg`: state encodings (IDLE=0, LAUNCH=1, WAIT=2, DELIVER=3), operand and product widths (4 / 8), and the default `DRAIN_CYC` / `TIMEOUT` values.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last_gnt`; outputs are `gnt_valid` and `gnt_idx`.
- Top: FSM, drain counter, operand/product registers, optional timeout counter.

## Test plan
- **Reset/drain:** hold `req0`=1 from reset release. Expect no `mult_start` for 15 cycles, then a grant to requester 0 and `busy` high throughout.
- **Single request:** `req0` with `a0`=9, `b0`=13, driven by a multiplier model. Expect exactly one `mult_start` pulse and `ack0` the cycle after `mult_done` rises, with `p0`=117 (8'h75) and `p1` unchanged.
- **Tie and fairness:** `req0` and `req1` high continuously, re-raised after each ack. Expect grants alternating 0,1,0,1, with (3,5)→15 and (15,15)→225 delivered to the correct port.
- **Late request:** `req1` rises during a requester-0 WAIT. Expect the requester-0 op to complete unaffected, then requester 1 granted after one IDLE cycle.
- **Mid-op reset:** `rst_n`=0 for one cycle during WAIT. Expect state IDLE, no ack, `p0`/`p1`=0, and a fresh 15-cycle drain.
- **Timeout (macro defined):** `mult_done` stuck at 0. Expect `ack0`=1, `err`=1 and `p0`=0 exactly 31 WAIT cycles after LAUNCH. With the macro undefined, no ack ever appears.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared definitions for the two-requester multiplier arbiter (mult_share_arb).
// Contents:
//   - state_e    : sequencer states IDLE=0, LAUNCH=1, WAIT=2, DELIVER=3
//   - OP_W       : operand width (4)
//   - PROD_W     : product width (8)
//   - operand_t  : operand word type
//   - product_t  : product word type
//   - DRAIN_CYC_DEF / TIMEOUT_DEF : default drain length and WAIT timeout
package mult_arb_pkg;

  localparam int OP_W          = 4;
  localparam int PROD_W        = 8;
  localparam int DRAIN_CYC_DEF = 15;
  localparam int TIMEOUT_DEF   = 31;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [PROD_W-1:0] product_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

endpackage

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if
// Bundles the requester-side and multiplier-side signals of mult_share_arb.
// Modports:
//   master : the arbiter itself (drives acks, products, multiplier launch)
//   slave  : the environment (requesters and the shared multiplier)
// Signals:
//   req0/req1, a0/b0, a1/b1 : request levels and operands from the requesters
//   ack0/ack1, p0/p1        : one-cycle ack and held product per requester
//   mult_start, mult_a/b    : launch pulse and operands to the multiplier
//   mult_done, mult_p       : completion level and product from the multiplier
//   busy, owner             : status (not idle / current or last grantee)
//   err                     : timeout flag, present only with MULT_ARB_TIMEOUT_EN
interface mult_share_arb_if;
  import mult_arb_pkg::*;

  logic     req0;
  logic     req1;
  operand_t a0;
  operand_t b0;
  operand_t a1;
  operand_t b1;
  logic     ack0;
  logic     ack1;
  product_t p0;
  product_t p1;
  logic     mult_start;
  operand_t mult_a;
  operand_t mult_b;
  logic     mult_done;
  product_t mult_p;
  logic     busy;
  logic     owner;
`ifdef MULT_ARB_TIMEOUT_EN
  logic     err;
`endif

  modport master (
    input  req0, req1, a0, b0, a1, b1, mult_done, mult_p,
    output ack0, ack1, p0, p1, mult_start, mult_a, mult_b, busy, owner
`ifdef MULT_ARB_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output req0, req1, a0, b0, a1, b1, mult_done, mult_p,
    input  ack0, ack1, p0, p1, mult_start, mult_a, mult_b, busy, owner
`ifdef MULT_ARB_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  in  : request levels
//   last_gnt  in  : index of the previous grantee
//   gnt_valid out : at least one request is present
//   gnt_idx   out : chosen requester (a lone request wins; on a tie the
//                   requester that did not win last time wins)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_gnt;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb
// Shares one 4x4 shift-add multiplier between two requesters. The winner's
// operands are latched, the multiplier is started with a one-cycle pulse, and
// once mult_done is seen the product is returned with a one-cycle ack.
// Optional feature macro: MULT_ARB_TIMEOUT_EN (bounded WAIT with err flag).
// Parameters:
//   DRAIN_CYC : cycles after reset release with no grant (default 15)
//   TIMEOUT   : WAIT cycle limit, only with MULT_ARB_TIMEOUT_EN (default 31)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mult_share_arb_if.master (requesters, multiplier, status)
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
`ifdef MULT_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_share_arb_if.master bus
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  state_e               state_q,      state_d;
  logic [DRAIN_W-1:0]   drain_q,      drain_d;
  logic                 last_gnt_q,   last_gnt_d;
  logic                 owner_q,      owner_d;
  operand_t             mult_a_q,     mult_a_d;
  operand_t             mult_b_q,     mult_b_d;
  product_t             p0_q,         p0_d;
  product_t             p1_q,         p1_d;
  logic                 ack0_q,       ack0_d;
  logic                 ack1_q,       ack1_d;
  logic                 mult_start_q, mult_start_d;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);
  logic [4:0]           tmo_q,        tmo_d;
  logic                 err_q,        err_d;
`endif

  logic gnt_valid;
  logic gnt_idx;

  rr_arb2 u_arb (
    .req       ({bus.req1, bus.req0}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mult_start_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // The drain window lets an un-reset multiplier finish whatever it
        // was doing before we trust its done flag again.
        if (drain_q != '0) begin
          drain_d = drain_q - 1'b1;
        end else if (gnt_valid) begin
          state_d      = ST_LAUNCH;
          owner_d      = gnt_idx;
          last_gnt_d   = gnt_idx;
          mult_a_d     = gnt_idx ? bus.a1 : bus.a0;
          mult_b_d     = gnt_idx ? bus.b1 : bus.b0;
          mult_start_d = 1'b1;
        end
      end

      // mult_done is deliberately ignored here: it may still be high from
      // the previous operation and is only cleared by this start pulse.
      ST_LAUNCH: begin
        state_d = ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      ST_WAIT: begin
        if (bus.mult_done) begin
          state_d = ST_DELIVER;
          if (owner_q) begin
            p1_d   = bus.mult_p;
            ack1_d = 1'b1;
          end else begin
            p0_d   = bus.mult_p;
            ack0_d = 1'b1;
          end
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // Give up after TIMEOUT WAIT cycles: ack with a zero product.
          state_d = ST_DELIVER;
          err_d   = 1'b1;
          if (owner_q) begin
            p1_d   = '0;
            ack1_d = 1'b1;
          end else begin
            p0_d   = '0;
            ack0_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
`endif
      end

      ST_DELIVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      drain_q      <= DRAIN_W'(DRAIN_CYC);
      last_gnt_q   <= 1'b1;
      owner_q      <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mult_start_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mult_start_q <= mult_start_d;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.p0         = p0_q;
  assign bus.p1         = p1_q;
  assign bus.mult_start = mult_start_q;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.owner      = owner_q;
  // busy is the only decoded output: anything but a drained IDLE.
  assign bus.busy       = (state_q != ST_IDLE) || (drain_q != '0);
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.err        = err_q;
`endif

endmodule
